// File: rtl/mdu_seq_if.sv
// Request/response bundle for the sequential multiply/divide unit.
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             mult;
  logic             signed_calc;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, mult, signed_calc, cancel, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, mult, signed_calc, cancel, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mdu_seq.sv
// Sequential multiply/divide: one result bit per cycle on operand magnitudes,
// with the sign applied once at the end so latency never depends on the data.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_mult;
  logic             r_signed;
  logic             r_negQ;
  logic             r_negR;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hiOut;
  logic [WIDTH-1:0] r_loOut;

  logic             w_aNeg;
  logic             w_bNeg;
  logic [WIDTH-1:0] w_aMag;
  logic [WIDTH-1:0] w_bMag;
  logic [WIDTH:0]   w_mulAdd;
  logic [WIDTH:0]   w_shift;
  logic             w_geq;
  logic [WIDTH-1:0] w_diff;
  logic [2*WIDTH-1:0] w_prodMag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_aNeg = r_signed & r_a[WIDTH-1];
  assign w_bNeg = r_signed & r_b[WIDTH-1];
  assign w_aMag = w_aNeg ? -r_a : r_a;
  assign w_bMag = w_bNeg ? -r_b : r_b;

  // Multiply: r_acc:r_lo is the running product, r_lo's LSB selects the add.
  assign w_mulAdd = r_lo[0] ? ({1'b0, r_acc} + {1'b0, r_opnd}) : {1'b0, r_acc};

  // Divide: r_acc is the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_shift = {r_acc, r_lo[WIDTH-1]};
  assign w_geq   = w_shift >= {1'b0, r_opnd};
  assign w_diff  = w_shift[WIDTH-1:0] - r_opnd;

  assign w_prodMag = {r_acc, r_lo};
  assign w_prod    = r_negQ ? -w_prodMag : w_prodMag;
  assign w_quo     = r_negQ ? -r_lo : r_lo;
  assign w_rem     = r_negR ? -r_acc : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_mult   <= 1'b0;
      r_signed <= 1'b0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hiOut  <= '0;
      r_loOut  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start && !bus.cancel) begin
          r_a      <= bus.a;
          r_b      <= bus.b;
          r_mult   <= bus.mult;
          r_signed <= bus.signed_calc;
          r_busy   <= 1'b1;
          r_state  <= PREP;
        end
      end else if (bus.cancel) begin
        r_busy  <= 1'b0;
        r_state <= IDLE;
      end else begin
        case (r_state)
          PREP: begin
            r_negQ  <= w_aNeg ^ w_bNeg;
            r_negR  <= w_aNeg;
            r_acc   <= '0;
            r_lo    <= r_mult ? w_bMag : w_aMag;
            r_opnd  <= r_mult ? w_aMag : w_bMag;
            r_count <= '0;
            r_state <= CALC;
          end
          CALC: begin
            if (r_mult) begin
              r_acc <= w_mulAdd[WIDTH:1];
              r_lo  <= {w_mulAdd[0], r_lo[WIDTH-1:1]};
            end else if (w_geq) begin
              r_acc <= w_diff;
              r_lo  <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= w_shift[WIDTH-1:0];
              r_lo  <= {r_lo[WIDTH-2:0], 1'b0};
            end
            r_count <= r_count + 1'b1;
            if (r_count == CW'(WIDTH - 1)) r_state <= FIX;
          end
          FIX: begin
            if (r_mult) begin
              {r_hiOut, r_loOut} <= w_prod;
              r_dbz <= 1'b0;
            end else if (r_b == '0) begin
              r_hiOut <= r_a;
              r_loOut <= '1;
              r_dbz   <= 1'b1;
            end else begin
              r_hiOut <= w_rem;
              r_loOut <= w_quo;
              r_dbz   <= 1'b0;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hiOut;
  assign bus.lo          = r_loOut;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand width; legal values 8, 16, 32, 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 mult  input  1  1 = multiply, 0 = divide.
REQ-006 signed_calc  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 a  input  WIDTH  multiplicand or dividend.
REQ-008 b  input  WIDTH  multiplier or divisor.
REQ-009 cancel  input  1  abort the operation in flight.
REQ-010 busy  output  1  operation in flight.
REQ-011 done  output  1  one-cycle pulse; hi/lo/div_by_zero are valid.
REQ-012 hi  output  WIDTH  product upper half, or remainder.
REQ-013 lo  output  WIDTH  product lower half, or quotient.
REQ-014 div_by_zero  output  1  last completed divide had b == 0.

Function
REQ-015 FSM states: IDLE, PREP, CALC, FIX; only IDLE accepts start.
REQ-016 IDLE with start=1 and cancel=0 latches a, b, mult and signed_calc, then goes to PREP; busy=1 from the next cycle.
REQ-017 PREP takes one cycle: forms operand magnitudes (negate when signed_calc and sign bit set), records the result signs, clears the iteration counter, then goes to CALC.
REQ-018 CALC takes exactly WIDTH cycles, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide; the counter wraps to FIX after iteration WIDTH-1.
REQ-019 FIX takes one cycle: applies the sign correction, registers hi/lo/div_by_zero, pulses done, returns to IDLE, and drops busy.
REQ-020 Fixed latency: done is high in the cycle after edge WIDTH+2, counted from the edge that sampled start (edge 0); the latency is independent of operand values.
REQ-021 Multiply result is {hi,lo} = full 2*WIDTH-bit product; when signed_calc=1 the product is negated if the operand signs differ.
REQ-022 Divide results: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign (signed) or unsigned.
REQ-023 Signed most-negative / -1: lo = most-negative value (wraps), hi = 0, no flag.
REQ-024 Divide with b == 0: latency unchanged, lo = all ones, hi = original a, div_by_zero = 1.
REQ-025 div_by_zero is updated only at FIX: cleared by any multiply, or by a divide with b != 0.
REQ-026 start while busy: ignored with no effect; the operands of the running operation are not disturbed.
REQ-027 start in the cycle done is high: accepted, because the state is already IDLE.
REQ-028 cancel while busy: next state IDLE, busy=0, no done; hi/lo/div_by_zero keep their prior values.
REQ-029 cancel and start both high in IDLE: cancel wins and start is ignored.
REQ-030 Outputs hi/lo/div_by_zero change only at FIX or reset; they hold between operations.

Reset
REQ-031 rst=1 at a rising edge forces state IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0 and counter=0, overriding start and cancel.
REQ-032 rst during PREP, CALC or FIX aborts the operation; no done is produced for it.

Verification (WIDTH=32)
REQ-033 signed mult a=FFFFFFFD (-3), b=00000005 -> done high at cycle 34 after start, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-034 unsigned mult a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-035 signed div a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; signed div a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-036 unsigned div a=00000007, b=0 -> lo=FFFFFFFF, hi=00000007, div_by_zero=1; a following mult clears it.
REQ-037 cancel at cycle 10 of a div -> busy=0 next cycle, no done, hi/lo unchanged; a start pulsed at cycle 5 of a mult is ignored (result unchanged); a new start the cycle after the cancel completes normally.
REQ-038 rst asserted at cycle 20 of a mult -> all outputs 0 next cycle, no done; start immediately after rst deasserts is accepted.
